// File: rtl/vectrex_pkg.sv
// Shared vectrex types and helpers: cart loader FSM states, default cart width,
// and the MSB-fill function used by both the loader and the cart mappers.
package vectrex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SKIP_WAIT,
    SKIP_RST
  } loader_state_t;

  localparam int CART_AW_DEF = 15;

  // Sets every bit at and below the most significant set bit; 0 stays 0.
  function automatic logic [31:0] smear(input logic [31:0] x);
    logic [31:0] r;
    r = x;
    for (int s = 1; s < 32; s = s * 2) begin
      r = r | (r >> s);
    end
    return r;
  endfunction

endpackage

// File: rtl/vectrex_cart_loader.sv
// HPS ioctl download -> cart RAM write path, cart mirror mask/size tracking,
// and core reset generation including the optional "skip logo" second reset.
module vectrex_cart_loader
  import vectrex_pkg::*;
#(
  parameter int CART_AW      = CART_AW_DEF,
  parameter int SKIP_TIMEOUT = 5000000,
  parameter int RESET_PULSE  = 1000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               skip_logo,
  input  logic               user_reset,
  output logic               cart_we,
  output logic [CART_AW-1:0] cart_waddr,
  output logic [7:0]         cart_wdata,
  output logic [CART_AW-1:0] cart_mask,
  output logic [CART_AW:0]   cart_size,
  output logic               core_reset,
  output logic               busy
);

  localparam int CW = $clog2(SKIP_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_INIT  = CW'(SKIP_TIMEOUT - RESET_PULSE);
  localparam logic [CW-1:0] PULSE_INIT = CW'(RESET_PULSE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  loader_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dl_q;

  logic dl_rise, dl_fall, wr_ok;
  logic [CART_AW-1:0] addr_w;
  logic [CART_AW-1:0] addr_smear;
  logic [CART_AW:0]   addr_p1;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign addr_w     = ioctl_addr[CART_AW-1:0];
  assign addr_smear = CART_AW'(smear(32'(addr_w)));
  assign addr_p1    = {1'b0, addr_w} + (CART_AW + 1)'(1);
  // The falling-edge cycle is still LOAD, so a strobe there is accepted.
  assign wr_ok      = (state_q == LOAD) && ioctl_wr && ((ioctl_addr >> CART_AW) == '0);
  assign busy       = (state_q != IDLE);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dl_rise) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (dl_fall) begin
            if (skip_logo) begin
              state_d = SKIP_WAIT;
              cnt_d   = WAIT_INIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        SKIP_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_d = SKIP_RST;
            cnt_d   = PULSE_INIT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SKIP_RST: begin
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dl_q       <= 1'b0;
      cart_we    <= 1'b0;
      cart_waddr <= '0;
      cart_wdata <= '0;
      cart_mask  <= '0;
      cart_size  <= '0;
      core_reset <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dl_q    <= ioctl_download;
      cart_we <= wr_ok;
      if (wr_ok) begin
        cart_waddr <= addr_w;
        cart_wdata <= ioctl_dout;
      end
      if (dl_rise) begin
        cart_mask <= '0;
        cart_size <= '0;
      end else if (wr_ok) begin
        cart_mask <= cart_mask | addr_smear;
        if (addr_p1 > cart_size) cart_size <= addr_p1;
      end
      core_reset <= user_reset | ioctl_download | (state_q == SKIP_RST);
    end
  end

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Self-checking bench for vectrex_cart_loader: scoreboard for the cart write
// stream plus directed checks of mask/size, busy and core reset timing.
`timescale 1ns/1ps
module tb_vectrex_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        skip_logo = 1'b0;
  logic        user_reset = 1'b0;
  logic        cart_we;
  logic [14:0] cart_waddr;
  logic [7:0]  cart_wdata;
  logic [14:0] cart_mask;
  logic [15:0] cart_size;
  logic        core_reset;
  logic        busy;

  vectrex_cart_loader #(
    .CART_AW(15),
    .SKIP_TIMEOUT(200),
    .RESET_PULSE(20)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .skip_logo(skip_logo),
    .user_reset(user_reset),
    .cart_we(cart_we),
    .cart_waddr(cart_waddr),
    .cart_wdata(cart_wdata),
    .cart_mask(cart_mask),
    .cart_size(cart_size),
    .core_reset(core_reset),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    int          cycle;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit accept);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (accept) sb.push_back('{a[14:0], d, cyc + 1});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl(input bit skip);
    skip_logo      = skip;
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && sb.size() != 0; i++) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every cart_we must match the oldest outstanding expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (cart_we === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_cart_we", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("cart_waddr", 32'(cart_waddr), 32'(e.addr));
          check("cart_wdata", 32'(cart_wdata), 32'(e.data));
          check("we_latency", 32'(cyc), 32'(e.cycle));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_cart_we", 32'(cart_we), 32'd0);
    check("rst_mask", 32'(cart_mask), 32'd0);
    check("rst_size", 32'(cart_size), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_core_reset", 32'(core_reset), 32'd0);

    // Sequential load 0x0000..0x1FFF
    start_dl();
    check("load_busy", 32'(busy), 32'd1);
    check("load_core_reset", 32'(core_reset), 32'd1);
    for (int i = 0; i < 8192; i++) begin
      wr(25'(i), 8'(i) ^ 8'(i >> 5), 1'b1);
      if (i % 1024 == 0) check("load_core_reset_hold", 32'(core_reset), 32'd1);
    end
    end_dl(1'b0);
    tick();
    drain();
    check("seq_mask", 32'(cart_mask), 32'h1FFF);
    check("seq_size", 32'(cart_size), 32'h2000);
    check("seq_busy_idle", 32'(busy), 32'd0);
    check("seq_core_reset_low", 32'(core_reset), 32'd0);

    // Single, out-of-order, out-of-range writes; write on falling edge; skip-logo timing
    start_dl();
    check("new_dl_mask_clr", 32'(cart_mask), 32'd0);
    check("new_dl_size_clr", 32'(cart_size), 32'd0);
    wr(25'h0500, 8'hA5, 1'b1);
    check("w500_mask", 32'(cart_mask), 32'h07FF);
    check("w500_size", 32'(cart_size), 32'h0501);
    wr(25'h0100, 8'h3C, 1'b1);
    check("w100_mask", 32'(cart_mask), 32'h07FF);
    check("w100_size", 32'(cart_size), 32'h0501);
    wr(25'h8000, 8'h77, 1'b0);
    check("w8000_mask", 32'(cart_mask), 32'h07FF);
    check("w8000_size", 32'(cart_size), 32'h0501);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0900;
    ioctl_dout = 8'h5A;
    sb.push_back('{15'h0900, 8'h5A, cyc + 1});
    end_dl(1'b1);  // edge T
    ioctl_wr = 1'b0;
    check("fall_wr_mask", 32'(cart_mask), 32'h0FFF);
    check("fall_wr_size", 32'(cart_size), 32'h0901);
    check("skip_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 205; k++) begin
      if (k == 50) skip_logo = 1'b0;
      tick();
      if (k >= 2) check($sformatf("skip_core_reset_T%0d", k), 32'(core_reset),
                        32'((k >= 181 && k <= 200) ? 1 : 0));
      if (k == 199) check("skip_busy_rst", 32'(busy), 32'd1);
      if (k == 200) check("skip_busy_done", 32'(busy), 32'd0);
    end
    drain();

    // New download aborts the skip sequence at cycle 190
    start_dl();
    wr(25'h0500, 8'h11, 1'b1);
    end_dl(1'b1);  // edge T
    for (int k = 1; k <= 189; k++) begin
      tick();
      if (k == 185) check("abort_pre_core_reset", 32'(core_reset), 32'd1);
    end
    ioctl_download = 1'b1;
    tick();        // edge T+190
    check("abort_core_reset", 32'(core_reset), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_mask_clr", 32'(cart_mask), 32'd0);
    check("abort_size_clr", 32'(cart_size), 32'd0);
    tick();
    check("abort_core_reset_hold", 32'(core_reset), 32'd1);
    end_dl(1'b0);
    check("abort_end_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 40; k++) begin
      check("abort_no_second_pulse", 32'(core_reset), 32'd0);
      tick();
    end

    // Zero-byte download with skip_logo still runs the skip sequence
    start_dl();
    end_dl(1'b1);
    check("zero_mask", 32'(cart_mask), 32'd0);
    check("zero_size", 32'(cart_size), 32'd0);
    check("zero_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 201; k++) begin
      tick();
      if (k == 100) check("zero_wait_low", 32'(core_reset), 32'd0);
      if (k == 190) check("zero_second_reset", 32'(core_reset), 32'd1);
      if (k == 201) check("zero_done", 32'(busy), 32'd0);
    end

    // user_reset pulses core_reset and keeps mask/size
    start_dl();
    wr(25'h0500, 8'h22, 1'b1);
    end_dl(1'b0);
    tick();
    drain();
    user_reset = 1'b1;
    tick();
    check("user_reset_core", 32'(core_reset), 32'd1);
    user_reset = 1'b0;
    tick();
    check("user_reset_release", 32'(core_reset), 32'd0);
    check("user_reset_mask", 32'(cart_mask), 32'h07FF);
    check("user_reset_size", 32'(cart_size), 32'h0501);

    // Block reset mid-LOAD, then writes while IDLE are ignored
    start_dl();
    wr(25'h0020, 8'h99, 1'b1);
    reset      = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0030;
    tick();
    ioctl_wr = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mask", 32'(cart_mask), 32'd0);
    check("midrst_size", 32'(cart_size), 32'd0);
    check("midrst_cart_we", 32'(cart_we), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    wr(25'h0040, 8'h55, 1'b0);
    tick();
    drain();
    check("idle_wr_busy", 32'(busy), 32'd0);
    check("idle_core_reset", 32'(core_reset), 32'd0);
    check("idle_wr_mask", 32'(cart_mask), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
